// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the lsu_32bit load/store unit.
// The optional misaligned-access trap is enabled with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Unlisted funct3 codes fall through to word accesses.
    function automatic lsu_size_t lsu_size(input logic [2:0] funct3);
        case (funct3)
            LSU_B, LSU_BU: lsu_size = SZ_BYTE;
            LSU_H, LSU_HU: lsu_size = SZ_HALF;
            default:       lsu_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (lsu_size(funct3))
            SZ_BYTE: lsu_be = 4'b0001 << addr_lo;
            SZ_HALF: lsu_be = 4'b0011 << {addr_lo[1], 1'b0};
            default: lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wlanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (lsu_size(funct3))
            SZ_BYTE: lsu_wlanes = {4{wdata[7:0]}};
            SZ_HALF: lsu_wlanes = {2{wdata[15:0]}};
            default: lsu_wlanes = wdata;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (lsu_size(funct3))
            SZ_BYTE: lsu_misaligned = 1'b0;
            SZ_HALF: lsu_misaligned = addr_lo[0];
            default: lsu_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_32bit_if.sv
// Core-side request/response and memory-side bus interfaces for lsu_32bit.
// Core side: master = core, slave = LSU. Memory side: master = LSU, slave = memory.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        bus_err;
    logic        misalign;

    modport master (
        output req_valid, is_store, funct3, addr, wdata,
        input  req_ready, resp_valid, rdata, bus_err, misalign
    );

    modport slave (
        input  req_valid, is_store, funct3, addr, wdata,
        output req_ready, resp_valid, rdata, bus_err, misalign
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load-data lane select and sign/zero extension.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

        case (i_funct3)
            LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
            LSU_BU:  o_data = {24'b0, w_byte};
            LSU_H:   o_data = {{16{w_half[15]}}, w_half};
            LSU_HU:  o_data = {16'b0, w_half};
            default: o_data = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_32bit.sv
// RV32I load/store unit: one aligned word request per access, valid/ready to the core.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_32bit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t r_state;
    lsu_state_t w_next;

    logic [1:0]       r_addr_lo;
    logic [2:0]       r_funct3;
    logic             r_is_store;
    logic [3:0]       r_be;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
    logic             r_misalign;

    logic             w_accept;
    logic             w_trap;
    logic             w_expire;
    logic [31:0]      w_ext;

    assign w_accept = core.req_valid & (r_state == IDLE) & ~reset;
    assign w_expire = (r_cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = lsu_misaligned(core.funct3, core.addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    lsu_load_extend u_load_extend (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr_lo),
        .i_mem_rdata (mem.mem_rdata),
        .o_data      (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory bus is driven only in BUSY so an idle LSU presents a quiet bus.
    always_comb begin
        w_next          = r_state;
        core.req_ready  = 1'b0;
        core.resp_valid = 1'b0;
        core.rdata      = '0;
        core.bus_err    = 1'b0;
        core.misalign   = 1'b0;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        mem.mem_be      = '0;
        mem.mem_addr    = '0;
        mem.mem_wdata   = '0;

        case (r_state)
            IDLE: begin
                core.req_ready = ~reset;
                if (core.req_valid & ~reset) begin
                    w_next = w_trap ? RESP : BUSY;
                end
            end
            BUSY: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_is_store;
                mem.mem_be    = r_be;
                mem.mem_addr  = r_mem_addr;
                mem.mem_wdata = r_wdata;
                if (mem.mem_ack | w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                core.resp_valid = 1'b1;
                core.rdata      = r_rdata;
                core.bus_err    = r_bus_err;
                core.misalign   = r_misalign;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_lo  <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_be       <= '0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr_lo  <= core.addr[1:0];
                        r_funct3   <= core.funct3;
                        r_is_store <= core.is_store;
                        r_be       <= lsu_be(core.funct3, core.addr[1:0]);
                        r_mem_addr <= {core.addr[31:2], 2'b00};
                        r_wdata    <= lsu_wlanes(core.funct3, core.wdata);
                        r_rdata    <= '0;
                        r_cnt      <= '0;
                        r_bus_err  <= 1'b0;
                        r_misalign <= w_trap;
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle takes priority over the timeout.
                    if (mem.mem_ack) begin
                        r_rdata <= r_is_store ? '0 : w_ext;
                    end else if (w_expire) begin
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_32bit.sv
// Scoreboard testbench for lsu_32bit: byte-level reference model, randomized traffic.
// Honours LSU_MISALIGN_TRAP_EN in the same way as the design.
module tb_lsu_32bit;
    import lsu_pkg::*;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_mem_if  mem ();

    lsu_32bit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core),
        .mem   (mem)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          issue_cyc;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    resp_t sb_q[$];
    bus_t  bus_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_resp_cyc = -100;
    int last_issue_cyc = 0;
    int ack_delay = 0;
    bit no_ack = 1'b0;

    logic [7:0]  ref_mem [64];
    logic [31:0] mem_words [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int sz(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem_words[a[5:2]] = v;
        for (int j = 0; j < 4; j++) ref_mem[{a[5:2], 2'b00} + j] = v[8*j +: 8];
    endtask

    // Memory responder: acks the request after ack_delay extra BUSY cycles; junk ack otherwise.
    initial begin : responder
        int busy;
        logic [3:0] idx;
        busy = 0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem.mem_req) begin
                busy++;
                if (!no_ack && busy == ack_delay + 1) begin
                    idx = mem.mem_addr[5:2];
                    mem.mem_ack = 1'b1;
                    mem.mem_rdata = mem_words[idx];
                    if (mem.mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem.mem_be[i]) mem_words[idx][8*i +: 8] = mem.mem_wdata[8*i +: 8];
                end else begin
                    mem.mem_ack = 1'b0;
                    mem.mem_rdata = $urandom;
                end
            end else begin
                if (busy > 0 && no_ack) check("timeout_req_cycles", busy, TMO);
                busy = 0;
                mem.mem_ack = 1'($urandom_range(0, 1));
                mem.mem_rdata = $urandom;
            end
        end
    end

    initial begin : bus_monitor
        bus_t cur;
        bit prev;
        prev = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (mem.mem_req && !prev) begin
                if (bus_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_req: addr 0x%08h", mem.mem_addr);
                end else begin
                    cur = bus_q.pop_front();
                    check("mem_addr", mem.mem_addr, cur.addr);
                    check("mem_be", 32'(mem.mem_be), 32'(cur.be));
                    check("mem_we", 32'(mem.mem_we), 32'(cur.we));
                    if (cur.we) check("mem_wdata", mem.mem_wdata, cur.wdata);
                end
            end else if (mem.mem_req) begin
                check("mem_addr_stable", mem.mem_addr, cur.addr);
                check("mem_be_stable", 32'(mem.mem_be), 32'(cur.be));
            end
            prev = mem.mem_req;
        end
    end

    initial begin : resp_monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (core.resp_valid) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: rdata 0x%08h", core.rdata);
                end else begin
                    r = sb_q.pop_front();
                    check("rdata", core.rdata, r.rdata);
                    check("bus_err", 32'(core.bus_err), 32'(r.err));
                    check("misalign", 32'(core.misalign), 32'(r.mis));
                    check("resp_latency", cyc - r.issue_cyc, r.lat);
                end
                last_resp_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input bit noack, input bit expect_resp);
        int n;
        int t;
        logic [31:0] base;
        logic [31:0] ea;
        bit trap;
        longint v;
        resp_t r;
        bus_t b;
        t = 0;
        while (!core.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!core.req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        n    = sz(f);
        base = {a[31:2], 2'b00};
        ea   = a & ~(32'(n - 1));
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a & 32'(n - 1)) != 0;
`else
        trap = 1'b0;
`endif
        ack_delay = dly;
        no_ack = noack;
        core.req_valid = 1'b1;
        core.is_store = st;
        core.funct3 = f;
        core.addr = a;
        core.wdata = wd;
        last_issue_cyc = cyc;
        r.issue_cyc = cyc;
        r.mis = trap;
        r.err = 1'b0;
        r.rdata = '0;
        r.lat = 1;
        if (!trap) begin
            b.addr = base;
            b.we = st;
            b.be = '0;
            b.wdata = '0;
            for (int i = 0; i < 4; i++) begin
                if (base + i >= ea && base + i < ea + n) b.be[i] = 1'b1;
                b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
            end
            bus_q.push_back(b);
            if (noack) begin
                r.err = 1'b1;
                r.lat = TMO + 1;
            end else begin
                r.lat = dly + 2;
                if (st) begin
                    for (int j = 0; j < n; j++) ref_mem[(int'(ea) + j) & 63] = wd[8*j +: 8];
                end else begin
                    v = 0;
                    for (int j = 0; j < n; j++) v = v | (longint'(ref_mem[(int'(ea) + j) & 63]) << (8 * j));
                    if ((f == 3'b000 || f == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
                        v = v - (longint'(1) << (8 * n));
                    r.rdata = v[31:0];
                end
            end
        end
        if (expect_resp) sb_q.push_back(r);
        @(negedge clk);
        core.req_valid = 1'b0;
        core.addr = $urandom;
        core.wdata = $urandom;
        core.funct3 = 3'($urandom_range(0, 7));
        core.is_store = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !core.req_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("wait_idle");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        core.req_valid = 1'b0;
        core.is_store = 1'b0;
        core.funct3 = '0;
        core.addr = '0;
        core.wdata = '0;
        for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom);

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(core.req_ready), 0);
        check("reset_resp_valid", 32'(core.resp_valid), 0);
        check("reset_mem_req", 32'(mem.mem_req), 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(core.req_ready), 1);

        issue(1'b1, LSU_B, 32'h0000_1003, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
        wait_idle();

        set_word(32'h0000_2000, 32'h0000_8000);
        issue(1'b0, LSU_B, 32'h0000_2001, 32'h0, 0, 1'b0, 1'b1);
        issue(1'b0, LSU_BU, 32'h0000_2001, 32'h0, 1, 1'b0, 1'b1);
        wait_idle();
        set_word(32'h0000_2000, 32'h8001_0000);
        issue(1'b0, LSU_H, 32'h0000_2002, 32'h0, 0, 1'b0, 1'b1);
        wait_idle();

        issue(1'b0, LSU_W, 32'h0000_0040, 32'h0, 0, 1'b1, 1'b1);
        wait_idle();

        // Reset on the third BUSY cycle must abandon the access silently.
        issue(1'b0, LSU_W, 32'h0000_0044, 32'h0, 1000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem.mem_req), 0);
        check("rst_mid_ready", 32'(core.req_ready), 0);
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", 32'(core.req_ready), 1);
        @(negedge clk);

        issue(1'b0, LSU_W, 32'h0000_3002, 32'h0, 0, 1'b0, 1'b1);
        wait_idle();

        issue(1'b1, LSU_W, 32'h0000_0010, 32'h1122_3344, 0, 1'b0, 1'b1);
        issue(1'b0, LSU_W, 32'h0000_0010, 32'h0, 0, 1'b0, 1'b1);
        check("b2b_accept_cycle", last_issue_cyc, last_resp_cyc + 1);
        wait_idle();

        issue(1'b0, LSU_W, 32'h0000_0020, 32'h0, int'(TMO) - 1, 1'b0, 1'b1);
        wait_idle();

        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  {26'($urandom), 6'($urandom)}, $urandom,
                  int'($urandom_range(0, 4)), ($urandom_range(0, 19) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
